char_stream_loader: RTL
=======================

# char_stream_loader

Upstream feeder for the decryption processor's character buffer. Accepts a byte stream over a valid/ready handshake (UART RX or keyboard decoder), drops non-printable bytes, and writes each kept character as a zero-extended 32-bit word into processor RAM from `BASE_ADDR` upward. It appends a zero terminator, reports the character count, and holds the processor off RAM while a message is loading.

## Interface
Parameters:
- `BASE_ADDR`, 1500: RAM word address of character 0.
- `BUF_LEN`, 108: buffer capacity in characters (12×9).
- `ADDR_W`, 12: RAM address width.

Ports:
- `clock`  in  1  single design clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a new message and clears the buffer count.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  8  ASCII byte.
- `in_last`  in  1  qualifies the current byte as the last of the message.
- `in_ready`  out  1  loader accepts the byte this cycle.
- `mem_we`  out  1  RAM write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  RAM word address.
- `mem_data`  out  32  `{24'b0, char}`, or 0 for the terminator.
- `char_count`  out  8  characters stored in the current message.
- `proc_hold`  out  1  processor must stay in reset and stay off RAM while high.
- `done`  out  1  message committed to RAM; level signal.
- `truncated`  out  1  buffer filled before `in_last` was seen; sticky until the next `start`.

## Operation
- States: IDLE, LOAD, TERM, DONE.
- Reset or power-up: state IDLE. All outputs 0, including `char_count`.
- IDLE: `in_ready`=0. `start` → LOAD with `char_count`←0 and `truncated`←0.
- LOAD: `in_ready` = `char_count`<`BUF_LEN` && !`start`. A byte is accepted on an edge where `in_valid` && `in_ready`.
  - Kept byte (0x20–0x7E): write `{24'b0, byte}` to `BASE_ADDR`+`char_count`, then `char_count`+1.
  - Other bytes: dropped, no write, no count change.
  - Accepted byte with `in_last`=1, kept or dropped: → TERM.
  - Kept byte that makes `char_count`==`BUF_LEN` without `in_last`: → TERM and `truncated`←1.
- TERM: lasts one cycle. If `char_count`<`BUF_LEN`, write 0 to `BASE_ADDR`+`char_count`; otherwise no write. Then → DONE.
- DONE: `in_ready`=0. `done` = (state==DONE) && !`mem_we`. `start` → LOAD with a fresh message.
- `start` while in LOAD or TERM aborts the current message: `char_count`←0, `truncated`←0, → LOAD. Words already written stay in RAM and are overwritten as the new message loads.
- `proc_hold` = (state is LOAD or TERM) || `mem_we`.
- Address arithmetic is `ADDR_W` bits and modulo 2^`ADDR_W`. With the default parameters the highest address used is 1607.

## Timing
- Accept edge N → `mem_we`=1 with address and data valid for exactly cycle N+1.
- `char_count` updates on the accept edge itself.
- Throughput: one character per cycle sustained.
- Terminator write is presented in the cycle after the TERM edge.
- `done` rises one cycle after the final `mem_we` pulse and stays high until `start` or reset.
- Minimum latency, single-character message: accept at edge 0 → char write in cycle 1 → terminator write in cycle 2 → `done` in cycle 3.
- `reset_n` asserted mid-message: outputs go to 0 immediately and asynchronously. An in-flight `mem_we` is dropped.

## Configuration
- `CHAR_LOADER_UPPERCASE_EN` defined: kept bytes 0x61–0x7A are stored minus 0x20, so the processor sees only upper-case letters. Filtering and counting are unchanged.
- Not defined: bytes are stored as received.

## Structure
- Shared package `char_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `CHAR_MIN`=0x20 and `CHAR_MAX`=0x7E;
  - the default `BASE_ADDR` and `BUF_LEN` constants, so the wrapper's memory mux uses the same values.
- One natural sub-module, `char_filter`: combinational classification (keep/drop) plus the optional case fold. It sits between `in_data` and the write register.
- The FSM, counter and write register stay in the top module.

## Test plan
- Reset, then `start`, then stream "HI" with `in_last` on 'I' → writes 72@1500, 73@1501, 0@1502; `char_count`=2; `done`=1 one cycle after the 1502 write; `truncated`=0.
- Stream 0x41, 0x0A, 0x42 with `in_last` on 0x42 → 0x0A is dropped; 65@1500, 66@1501, 0@1502; `char_count`=2.
- Stream 110 printable bytes, no `in_last` → writes 1500–1607, no terminator, `in_ready`=0 after byte 108, `truncated`=1, `char_count`=108.
- Send 5 bytes, pulse `start` together with `in_valid` on byte 6 → byte 6 is not accepted, `char_count`=0, and the next byte is written to 1500.
- Send 0x62 with `CHAR_LOADER_UPPERCASE_EN` defined → 66@1500; without the macro → 98@1500.
- Drop `reset_n` in the cycle `mem_we`=1 → `mem_we`, `proc_hold`, `done` and `char_count` go to 0 immediately; state IDLE; `in_ready`=0 until `start`.

Source files
------------

// File: rtl/char_loader_pkg.sv
// Shared types and constants for the character stream loader and its memory mux.
// Optional feature macro: CHAR_LOADER_UPPERCASE_EN (see char_filter).
package char_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TERM = 2'd2,
    ST_DONE = 2'd3
  } loader_state_t;

  localparam logic [7:0] CHAR_MIN = 8'h20;
  localparam logic [7:0] CHAR_MAX = 8'h7E;

  localparam int unsigned DEFAULT_BASE_ADDR = 1500;
  localparam int unsigned DEFAULT_BUF_LEN   = 108;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned COUNT_W = 8;
  localparam int unsigned DATA_W  = 32;

endpackage

// File: rtl/char_filter.sv
// Printable-character classifier with optional lower-to-upper case fold.
// Fold is enabled by defining CHAR_LOADER_UPPERCASE_EN; otherwise bytes pass unchanged.
module char_filter
  import char_loader_pkg::*;
(
  input  logic [CHAR_W-1:0] data,
  output logic              keep_c,
  output logic [CHAR_W-1:0] char_c
);

  always_comb begin
    keep_c = (data >= CHAR_MIN) && (data <= CHAR_MAX);
    char_c = data;
`ifdef CHAR_LOADER_UPPERCASE_EN
    if ((data >= 8'h61) && (data <= 8'h7A)) begin
      char_c = data - 8'h20;
    end
`else
`endif
  end

endmodule

// File: rtl/char_stream_loader.sv
// Loads a filtered byte stream into processor RAM as 32-bit words with a zero terminator.
// Define CHAR_LOADER_UPPERCASE_EN to store lower-case letters as upper case.
module char_stream_loader
  import char_loader_pkg::*;
#(
  parameter int unsigned BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned BUF_LEN   = DEFAULT_BUF_LEN,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [CHAR_W-1:0]  in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_data,
  output logic [COUNT_W-1:0] char_count,
  output logic               proc_hold,
  output logic               done,
  output logic               truncated
);

  loader_state_t      state;
  loader_state_t      state_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic               trunc_nxt;
  logic               we_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DATA_W-1:0]  data_nxt;

  logic               keep_c;
  logic [CHAR_W-1:0]  char_c;
  logic               room_c;
  logic               accept_c;
  logic               fills_c;
  logic [ADDR_W-1:0]  slot_addr_c;

  char_filter u_filter (
    .data   (in_data),
    .keep_c (keep_c),
    .char_c (char_c)
  );

  assign room_c      = 32'(char_count) < BUF_LEN;
  assign fills_c     = (32'(char_count) + 32'd1) == BUF_LEN;
  assign in_ready    = (state == ST_LOAD) && room_c && !start;
  assign accept_c    = in_valid && in_ready;
  assign slot_addr_c = ADDR_W'(BASE_ADDR) + ADDR_W'(char_count);
  assign proc_hold   = (state == ST_LOAD) || (state == ST_TERM) || mem_we;
  // done waits until the last RAM write has left the bus
  assign done        = (state == ST_DONE) && !mem_we;

  // Next-state, counter and write-register logic; start aborts from any state
  always_comb begin
    state_nxt = state;
    count_nxt = char_count;
    trunc_nxt = truncated;
    we_nxt    = 1'b0;
    addr_nxt  = mem_addr;
    data_nxt  = mem_data;
    if (start) begin
      state_nxt = ST_LOAD;
      count_nxt = '0;
      trunc_nxt = 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept_c) begin
            if (keep_c) begin
              we_nxt    = 1'b1;
              addr_nxt  = slot_addr_c;
              data_nxt  = DATA_W'(char_c);
              count_nxt = char_count + COUNT_W'(1);
            end
            if (in_last) begin
              state_nxt = ST_TERM;
            end else if (keep_c && fills_c) begin
              state_nxt = ST_TERM;
              trunc_nxt = 1'b1;
            end
          end
        end
        ST_TERM: begin
          if (room_c) begin
            we_nxt   = 1'b1;
            addr_nxt = slot_addr_c;
            data_nxt = '0;
          end
          state_nxt = ST_DONE;
        end
        ST_IDLE: ;
        ST_DONE: ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      char_count <= '0;
      truncated  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      state      <= state_nxt;
      char_count <= count_nxt;
      truncated  <= trunc_nxt;
      mem_we     <= we_nxt;
      mem_addr   <= addr_nxt;
      mem_data   <= data_nxt;
    end
  end

endmodule
